// File: rtl/toggle_activity_counter.sv
// Switching-activity monitor: counts bit toggles on A over WINDOW cycles and hands one saturating
// total per window to the consumer. Define TOGGLE_RISE_ONLY_EN to count only 0->1 transitions.
module toggle_activity_counter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned WINDOW = 1024
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             EN,
    input  logic [WIDTH-1:0] A,
    input  logic             Y_READY,
    output logic             Y_VALID,
    output logic [CNT_W-1:0] Y_COUNT,
    output logic             Y_SAT,
    output logic             Y_OVERRUN
);

    localparam int unsigned PC_W = $clog2(WIDTH + 1);
    localparam int unsigned WC_W = $clog2(WINDOW);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             y_valid_q, y_valid_d;
    logic [CNT_W-1:0] y_count_q, y_count_d;
    logic             y_sat_q, y_sat_d;
    logic             y_ovr_q, y_ovr_d;

    logic [WIDTH-1:0] toggle;
    logic [PC_W-1:0]  pcnt;
    logic [CNT_W:0]   sum_ext;
    logic             sat_add;
    logic [CNT_W-1:0] sum_sat;
    logic             win_close;

`ifdef TOGGLE_RISE_ONLY_EN
    assign toggle = A & ~sample_q;
`else
    assign toggle = A ^ sample_q;
`endif

    always_comb begin
        pcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pcnt = pcnt + PC_W'(toggle[i]);
        end
    end

    // One extra bit catches the carry out so the add can clamp at all-ones.
    assign sum_ext = {1'b0, acc_q} + {{(CNT_W + 1 - PC_W){1'b0}}, pcnt};
    assign sat_add = sum_ext[CNT_W];
    assign sum_sat = sat_add ? '1 : sum_ext[CNT_W-1:0];

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        acc_d     = acc_q;
        sat_d     = sat_q;
        wcnt_d    = wcnt_q;
        win_close = 1'b0;
        if (!EN) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            sat_d   = 1'b0;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_PRIME;
                ST_PRIME: begin
                    sample_d = A;
                    state_d  = ST_RUN;
                end
                ST_RUN: begin
                    sample_d = A;
                    if (wcnt_q == WC_W'(WINDOW - 1)) begin
                        win_close = 1'b1;
                        acc_d     = '0;
                        sat_d     = 1'b0;
                        wcnt_d    = '0;
                    end else begin
                        acc_d  = sum_sat;
                        sat_d  = sat_q | sat_add;
                        wcnt_d = wcnt_q + WC_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A closing window loads only into an empty or simultaneously drained output slot.
    always_comb begin
        y_valid_d = y_valid_q;
        y_count_d = y_count_q;
        y_sat_d   = y_sat_q;
        y_ovr_d   = y_ovr_q;
        if (win_close) begin
            if (!y_valid_q || Y_READY) begin
                y_valid_d = 1'b1;
                y_count_d = sum_sat;
                y_sat_d   = sat_q | sat_add;
            end else begin
                y_ovr_d = 1'b1;
            end
        end else if (y_valid_q && Y_READY) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q   <= ST_IDLE;
            sample_q  <= '0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            wcnt_q    <= '0;
            y_valid_q <= 1'b0;
            y_count_q <= '0;
            y_sat_q   <= 1'b0;
            y_ovr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            wcnt_q    <= wcnt_d;
            y_valid_q <= y_valid_d;
            y_count_q <= y_count_d;
            y_sat_q   <= y_sat_d;
            y_ovr_q   <= y_ovr_d;
        end
    end

    assign Y_VALID   = y_valid_q;
    assign Y_COUNT   = y_count_q;
    assign Y_SAT     = y_sat_q;
    assign Y_OVERRUN = y_ovr_q;

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Directed bench for toggle_activity_counter: a 16-bit-count instance and a 6-bit-count instance
// share one stimulus stream so the saturating case is observed alongside the normal one.
module tb_toggle_activity_counter;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned WINDOW = 16;
`ifdef TOGGLE_RISE_ONLY_EN
    localparam int unsigned EXP_ALT = 64;
`else
    localparam int unsigned EXP_ALT = 128;
`endif

    logic             CK;
    logic             RN;
    logic             EN;
    logic [WIDTH-1:0] A;
    logic             Y_READY;
    logic             Y_VALID;
    logic [15:0]      Y_COUNT;
    logic             Y_SAT;
    logic             Y_OVERRUN;
    logic             s_valid;
    logic [5:0]       s_count;
    logic             s_sat;
    logic             s_ovr;

    int checks   = 0;
    int failures = 0;
    bit alt;

    toggle_activity_counter #(.WIDTH(WIDTH), .CNT_W(16), .WINDOW(WINDOW)) dut (
        .CK(CK), .RN(RN), .EN(EN), .A(A), .Y_READY(Y_READY),
        .Y_VALID(Y_VALID), .Y_COUNT(Y_COUNT), .Y_SAT(Y_SAT), .Y_OVERRUN(Y_OVERRUN)
    );

    toggle_activity_counter #(.WIDTH(WIDTH), .CNT_W(6), .WINDOW(WINDOW)) dut_sat (
        .CK(CK), .RN(RN), .EN(EN), .A(A), .Y_READY(Y_READY),
        .Y_VALID(s_valid), .Y_COUNT(s_count), .Y_SAT(s_sat), .Y_OVERRUN(s_ovr)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, settle, then step the alternating pattern for the next edge.
    task automatic tick();
        @(posedge CK);
        #1;
        if (alt) A = ~A;
    endtask

    initial begin
        RN = 1'b0; EN = 1'b1; A = 8'h00; Y_READY = 1'b1; alt = 1'b1;

        // Reset with A toggling and EN high
        tick(); tick();
        check("rst_valid", Y_VALID, 0);
        check("rst_count", Y_COUNT, 0);
        check("rst_sat", Y_SAT, 0);
        check("rst_ovr", Y_OVERRUN, 0);
        check("rst_sat_count", s_count, 0);
        RN = 1'b1;

        // e0 enters PRIME; first close lands on e17
        for (int i = 0; i < 17; i++) begin
            tick();
            check("startup_no_valid", Y_VALID, 0);
        end
        tick();
        check("w1_valid", Y_VALID, 1);
        check("w1_count", Y_COUNT, EXP_ALT);
        check("w1_sat", Y_SAT, 0);
        check("w1_ovr", Y_OVERRUN, 0);
        check("sat_w1_count", s_count, 63);
        check("sat_w1_sat", s_sat, 1);

        // Pulse is one cycle wide, next one 16 cycles later
        for (int i = 0; i < 15; i++) begin
            tick();
            check("w2_gap_valid", Y_VALID, 0);
        end
        tick();
        check("w2_valid", Y_VALID, 1);
        check("w2_count", Y_COUNT, EXP_ALT);

        // Hold, then accept exactly on the close edge
        Y_READY = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("hold_valid", Y_VALID, 1);
            check("hold_count", Y_COUNT, EXP_ALT);
        end
        Y_READY = 1'b1;
        tick();
        check("simul_valid", Y_VALID, 1);
        check("simul_count", Y_COUNT, EXP_ALT);
        check("simul_ovr", Y_OVERRUN, 0);
        tick();
        check("simul_drain_valid", Y_VALID, 0);

        // Backpressure: first close loads, second close is dropped
        Y_READY = 1'b0;
        repeat (15) tick();
        check("bp_load_valid", Y_VALID, 1);
        check("bp_load_ovr", Y_OVERRUN, 0);
        repeat (15) tick();
        check("bp_pre_drop_ovr", Y_OVERRUN, 0);
        tick();
        check("bp_drop_valid", Y_VALID, 1);
        check("bp_drop_count", Y_COUNT, EXP_ALT);
        check("bp_drop_ovr", Y_OVERRUN, 1);
        repeat (9) tick();
        check("bp_late_valid", Y_VALID, 1);
        check("bp_late_count", Y_COUNT, EXP_ALT);
        Y_READY = 1'b1;
        tick();
        check("bp_xfer_valid", Y_VALID, 0);
        repeat (5) tick();
        check("bp_wait_valid", Y_VALID, 0);
        tick();
        check("bp_next_valid", Y_VALID, 1);
        check("bp_next_count", Y_COUNT, EXP_ALT);
        check("bp_ovr_sticky", Y_OVERRUN, 1);

        // Drop EN at RUN cycle 8, re-enable three cycles later
        repeat (8) tick();
        EN = 1'b0;
        repeat (3) tick();
        check("abort_valid", Y_VALID, 0);
        EN = 1'b1; alt = 1'b0; A = 8'h00;
        repeat (7) tick();
        A = 8'h01;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort_no_valid", Y_VALID, 0);
        end
        tick();
        check("reen_valid", Y_VALID, 1);
        check("reen_count", Y_COUNT, 1);
        check("reen_sat", Y_SAT, 0);
        check("sat_reen_count", s_count, 1);
        check("sat_reen_sat", s_sat, 0);

        // Constant A: empty window
        repeat (15) tick();
        tick();
        check("quiet_valid", Y_VALID, 1);
        check("quiet_count", Y_COUNT, 0);
        check("quiet_sat", Y_SAT, 0);
        check("sat_quiet_count", s_count, 0);
        check("sat_quiet_sat", s_sat, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toggle_activity_counter.md
Name: toggle_activity_counter

Overview:
- Switching-activity monitor that sits directly downstream of a bank of standard-cell outputs, such as INV/AND instance Y nets.
- Samples the monitored nets every cycle and counts bit toggles over a fixed window.
- Delivers one saturating toggle total per window to the thermal power-estimation consumer over a valid/ready handshake.
- Provides the per-window switching activity that the thermal model converts to dynamic power.

Parameters:
- WIDTH, 8: number of monitored nets on A.
- CNT_W, 16: width of the accumulator and of Y_COUNT.
- WINDOW, 1024: counting cycles per window; must be ≥ 2.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RN  input  1  reset, synchronous and active-low.
- EN  input  1  monitor enable.
- A  input  WIDTH  monitored nets.
- Y_READY  input  1  consumer accepts the result.
- Y_VALID  output  1  result held in Y_COUNT/Y_SAT is valid.
- Y_COUNT  output  CNT_W  toggle total for the completed window.
- Y_SAT  output  1  accumulator saturated during the reported window.
- Y_OVERRUN  output  1  sticky flag: a window result was dropped.

Behaviour:
- Clocking and reset:
  - One clock, CK.
  - Reset is synchronous, active-low on RN.
  - RN=0 at a clock edge sets: state IDLE, Y_VALID=0, Y_COUNT=0, Y_SAT=0, Y_OVERRUN=0, accumulator=0, window counter=0, sample register=0.
  - Reset mid-window discards all partial state.
- State machine:
  - IDLE → PRIME when EN=1.
  - PRIME (exactly one cycle): loads the sample register with A and counts nothing; → RUN.
  - RUN: each cycle, toggle vector = A XOR sample register; popcount is added to the accumulator; sample register ← A; window counter increments.
  - Any state → IDLE when EN=0; the accumulator and window counter clear and the partial window is discarded.
- Window close:
  - Occurs in the RUN cycle where window counter = WINDOW-1.
  - The result is accumulator + that cycle's popcount, saturated.
  - The result is offered to the output register.
  - The accumulator and counter clear and the next window starts on the following cycle with no gap; state stays RUN.
- Arithmetic:
  - Popcount width is clog2(WIDTH+1).
  - The sum saturates at 2^CNT_W-1.
  - The internal saturation flag sets on any saturating add and clears at window start.
  - That flag is reported as Y_SAT alongside the window's Y_COUNT.
- Latency: Y_VALID rises with the new Y_COUNT on the edge ending the window-close cycle (one cycle after the last counted sample is presented).
- Output handshake:
  - A transfer occurs when Y_VALID & Y_READY at a clock edge.
  - Y_COUNT and Y_SAT are stable while Y_VALID=1 and no transfer occurs.
  - Window close with no valid result held, or with a transfer that same cycle: the new result loads and Y_VALID=1.
  - Window close while Y_VALID=1 & Y_READY=0: the new result is dropped, the held result is kept, and Y_OVERRUN←1 until reset.
  - Transfer without a window close: Y_VALID←0.
  - EN=0 does not affect a held result; Y_VALID stays until it is accepted.
- Y_OVERRUN clears only on reset.

Optional Feature:
- Macro: TOGGLE_RISE_ONLY_EN.
- Defined: only 0→1 transitions are counted; toggle vector = A & ~sample register.
- Undefined: both edges are counted; toggle vector = A XOR sample register.
- Everything else is identical.

Test Plan (WIDTH=8, CNT_W=16, WINDOW=16 unless noted):
1. Reset: RN=0 for 2 cycles with A toggling and EN=1 → Y_VALID=0, Y_COUNT=0, Y_SAT=0, Y_OVERRUN=0; no Y_VALID until PRIME+16 cycles after RN=1.
2. Steady alternation: EN=1, A alternating 0x00/0xFF every cycle, Y_READY=1 → Y_VALID pulses 1 cycle every 16 cycles, first pulse 17 cycles after PRIME entry, Y_COUNT=128, Y_SAT=0. With TOGGLE_RISE_ONLY_EN: Y_COUNT=64.
3. Backpressure: same stimulus, Y_READY=0 for 40 cycles → Y_COUNT holds the first result (128); Y_OVERRUN=1 after the second window close. Then Y_READY=1 → transfer, Y_VALID=1 again only at the next window close; Y_OVERRUN stays 1.
4. Saturation: build with CNT_W=6, alternating 0xFF → Y_COUNT=63, Y_SAT=1. Next window with constant A → Y_COUNT=0, Y_SAT=0.
5. Enable drop: EN=0 at RUN cycle 8 of a window, EN=1 three cycles later → no Y_VALID for the aborted window. Next result appears 17 cycles after re-enable with only fresh-window toggles; single toggle pattern 0x01 flipping once → Y_COUNT=1.
6. Simultaneous accept and close: Y_VALID=1, Y_READY raised exactly on a window-close cycle → old result transfers, new result loads the same edge, Y_VALID stays 1, Y_OVERRUN=0.
